cas_pulse_gen: RTL and testbench

Converts a byte stream from a loaded CAS image into the TRS-80 Level II 500-baud cassette pulse waveform that feeds the machine's cassette input. It sits between the download/file-read path (upstream, byte handshake) and the ht1080z core's tape input (downstream, one-bit pulse line). It runs in the system clock domain at 42 MHz. Leader, sync byte and checksum bytes are carried in the CAS data itself; this block only serialises.

---
 rtl/cas_pulse_gen_if.sv | 9 +
 rtl/cas_pulse_gen.sv | 124 ++++++++++++
 tb/tb_cas_pulse_gen.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cas_pulse_gen_if.sv
// Byte handshake between the CAS file-read path and the cassette pulse serialiser.
interface cas_pulse_gen_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/cas_pulse_gen.sv
// Serialises CAS bytes, MSB first, into the TRS-80 Level II 500-baud pulse waveform.
module cas_pulse_gen #(
    parameter int unsigned CELL_CYC  = 84000,
    parameter int unsigned PULSE_CYC = 4200,
    parameter int unsigned CNT_W     = 17
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             motor,
    cas_pulse_gen_if.slave   in_if,
    output logic             cas_pulse,
    output logic             busy,
    output logic             byte_done
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CELL_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_END = CNT_W'(PULSE_CYC);
    localparam logic [CNT_W-1:0] DATA_BEG  = CNT_W'(CELL_CYC / 2);
    localparam logic [CNT_W-1:0] DATA_END  = CNT_W'(CELL_CYC / 2 + PULSE_CYC);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       hold, hold_nxt;
    logic             hold_full, hold_full_nxt;
    logic [7:0]       shifter, shifter_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ready_q;
    logic             pulse_nxt;
    logic             done_nxt;
    logic             accept;
    logic             cur_bit;
    logic             pulse_on;

    assign in_if.in_ready = ready_q;
    assign busy           = (state == RUN);
    assign accept         = in_if.in_valid && ready_q;
    assign cur_bit        = shifter[bit_idx];

    // Clock pulse opens every cell; data pulse at mid-cell only for a 1 bit.
    assign pulse_on = (cnt < PULSE_END) ||
                      (cur_bit && (cnt >= DATA_BEG) && (cnt < DATA_END));

    always_comb begin
        state_nxt     = state;
        hold_nxt      = hold;
        hold_full_nxt = hold_full;
        shifter_nxt   = shifter;
        bit_idx_nxt   = bit_idx;
        cnt_nxt       = cnt;
        pulse_nxt     = 1'b0;
        done_nxt      = 1'b0;

        if (accept) begin
            hold_nxt      = in_if.in_data;
            hold_full_nxt = 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (hold_full && motor) begin
                    shifter_nxt   = hold;
                    hold_full_nxt = 1'b0;
                    bit_idx_nxt   = 3'd7;
                    cnt_nxt       = '0;
                    state_nxt     = RUN;
                end
            end
            RUN: begin
                // With the motor off everything in the shifter path holds its value.
                if (motor) begin
                    pulse_nxt = pulse_on;
                    if (cnt == CNT_LAST) begin
                        cnt_nxt = '0;
                        if (bit_idx != 3'd0) begin
                            bit_idx_nxt = bit_idx - 3'd1;
                        end else begin
                            done_nxt = 1'b1;
                            if (hold_full) begin
                                shifter_nxt   = hold;
                                hold_full_nxt = 1'b0;
                                bit_idx_nxt   = 3'd7;
                            end else begin
                                state_nxt = IDLE;
                            end
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= IDLE;
            hold      <= '0;
            hold_full <= 1'b0;
            shifter   <= '0;
            bit_idx   <= '0;
            cnt       <= '0;
            ready_q   <= 1'b1;
            cas_pulse <= 1'b0;
            byte_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold      <= hold_nxt;
            hold_full <= hold_full_nxt;
            shifter   <= shifter_nxt;
            bit_idx   <= bit_idx_nxt;
            cnt       <= cnt_nxt;
            ready_q   <= ~hold_full_nxt;
            cas_pulse <= pulse_nxt;
            byte_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_cas_pulse_gen.sv
// Directed bench: waveform decoder checks each serialised byte against a scoreboard.
module tb_cas_pulse_gen;

    localparam int unsigned CELL  = 16;
    localparam int unsigned PULSE = 2;
    localparam int unsigned HALF  = CELL / 2;

    logic clk_sys = 1'b0;
    logic reset;
    logic motor;
    logic cas_pulse;
    logic busy;
    logic byte_done;

    cas_pulse_gen_if bus ();

    cas_pulse_gen #(.CELL_CYC(CELL), .PULSE_CYC(PULSE), .CNT_W(5)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .motor     (motor),
        .in_if     (bus),
        .cas_pulse (cas_pulse),
        .busy      (busy),
        .byte_done (byte_done)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;
    int rel    = 0;
    int dn_cnt = 0;
    logic [7:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
        rel++;
    endtask

    task automatic run_to(input int target);
        while (rel < target) tick();
    endtask

    task automatic offer(input logic [7:0] b);
        chk("offer_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        sb.push_back(b);
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Waveform decoder: classifies rises by motor-running cycles since the last clock pulse.
    logic       have_clk, cur_bit, prev_cas, mot_prev;
    logic [7:0] shreg;
    int         nbits, acc, hi_len;
    logic [7:0] exp_b;

    always @(negedge clk_sys) begin
        if (reset) begin
            have_clk = 1'b0; cur_bit = 1'b0; prev_cas = 1'b0; mot_prev = motor;
            shreg = '0; nbits = 0; acc = 0; hi_len = 0;
        end else begin
            if (cas_pulse && !prev_cas) begin
                chk("rise_busy", {31'd0, busy}, 32'd1);
                if (have_clk && acc == HALF && !cur_bit) begin
                    cur_bit = 1'b1;
                end else if (!have_clk || acc == CELL) begin
                    if (have_clk) begin
                        shreg = {shreg[6:0], cur_bit};
                        nbits++;
                    end
                    have_clk = 1'b1;
                    cur_bit  = 1'b0;
                    acc      = 0;
                end else begin
                    chk("pulse_gap", acc, CELL);
                end
            end
            if (!cas_pulse && prev_cas) begin
                chk("pulse_width", hi_len, PULSE);
                hi_len = 0;
            end
            if (cas_pulse) hi_len++;
            if (byte_done) begin
                if (have_clk) begin
                    shreg = {shreg[6:0], cur_bit};
                    nbits++;
                end
                chk("bit_count", nbits, 8);
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 0, 1);
                end else begin
                    exp_b = sb.pop_front();
                    chk("byte_value", {24'd0, shreg}, {24'd0, exp_b});
                end
                have_clk = 1'b0; cur_bit = 1'b0; nbits = 0; shreg = '0;
                dn_cnt++;
            end
            if (mot_prev) acc++;
            mot_prev = motor;
            prev_cas = cas_pulse;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "time limit reached");
    end

    int d0;

    initial begin
        reset = 1'b1;
        motor = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) tick();
        chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_cas",   {31'd0, cas_pulse}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_done",  {31'd0, byte_done}, 32'd0);
        reset = 1'b0;
        repeat (3) tick();

        // Single 0x80: start latency, pulse positions, end of byte.
        rel = 0;
        offer(8'h80);
        chk("t1_ready_low", {31'd0, bus.in_ready}, 32'd0);
        chk("t1_busy_r1", {31'd0, busy}, 32'd0);
        tick();
        chk("t1_busy_r2", {31'd0, busy}, 32'd1);
        chk("t1_cas_r2", {31'd0, cas_pulse}, 32'd0);
        tick();
        chk("t1_cas_r3", {31'd0, cas_pulse}, 32'd1);
        tick();
        chk("t1_cas_r4", {31'd0, cas_pulse}, 32'd1);
        tick();
        chk("t1_cas_r5", {31'd0, cas_pulse}, 32'd0);
        run_to(10);
        chk("t1_cas_r10", {31'd0, cas_pulse}, 32'd0);
        tick();
        chk("t1_data_r11", {31'd0, cas_pulse}, 32'd1);
        run_to(27);
        chk("t1_nodata_r27", {31'd0, cas_pulse}, 32'd0);
        run_to(129);
        chk("t1_busy_r129", {31'd0, busy}, 32'd1);
        chk("t1_done_r129", {31'd0, byte_done}, 32'd0);
        tick();
        chk("t1_done_r130", {31'd0, byte_done}, 32'd1);
        chk("t1_busy_r130", {31'd0, busy}, 32'd0);
        tick();
        chk("t1_done_r131", {31'd0, byte_done}, 32'd0);
        repeat (3) tick();

        // 0x55 then 0xAA back to back.
        rel = 0;
        offer(8'h55);
        run_to(3);
        offer(8'hAA);
        chk("t2_ready_r4", {31'd0, bus.in_ready}, 32'd0);
        run_to(129);
        chk("t2_ready_r129", {31'd0, bus.in_ready}, 32'd0);
        tick();
        chk("t2_ready_r130", {31'd0, bus.in_ready}, 32'd1);
        chk("t2_done_r130", {31'd0, byte_done}, 32'd1);
        chk("t2_busy_r130", {31'd0, busy}, 32'd1);
        tick();
        chk("t2_clk_r131", {31'd0, cas_pulse}, 32'd1);
        run_to(258);
        chk("t2_done_r258", {31'd0, byte_done}, 32'd1);
        chk("t2_busy_r258", {31'd0, busy}, 32'd0);
        repeat (3) tick();

        // 0xFF: two pulses per cell, one byte_done.
        d0 = dn_cnt;
        rel = 0;
        offer(8'hFF);
        run_to(11);
        chk("t3_data_r11", {31'd0, cas_pulse}, 32'd1);
        run_to(131);
        chk("t3_done_once", dn_cnt, d0 + 1);
        repeat (3) tick();

        // Motor freeze for 40 cycles at cnt=5 of bit 5 (third cell).
        rel = 0;
        offer(8'hA5);
        run_to(39);
        motor = 1'b0;
        repeat (40) begin
            tick();
            chk("t4_frozen_cas", {31'd0, cas_pulse}, 32'd0);
        end
        chk("t4_frozen_busy", {31'd0, busy}, 32'd1);
        motor = 1'b1;
        run_to(82);
        chk("t4_cas_r82", {31'd0, cas_pulse}, 32'd0);
        tick();
        chk("t4_data_r83", {31'd0, cas_pulse}, 32'd1);
        run_to(169);
        chk("t4_done_r169", {31'd0, byte_done}, 32'd0);
        tick();
        chk("t4_done_r170", {31'd0, byte_done}, 32'd1);
        repeat (3) tick();

        // Reset mid-byte with the holding register full.
        rel = 0;
        offer(8'h3C);
        run_to(3);
        offer(8'h99);
        run_to(50);
        d0 = dn_cnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        chk("t5_cas", {31'd0, cas_pulse}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_ready", {31'd0, bus.in_ready}, 32'd1);
        repeat (20) tick();
        chk("t5_no_done", dn_cnt, d0);
        chk("t5_idle_cas", {31'd0, cas_pulse}, 32'd0);
        rel = 0;
        offer(8'hC3);
        chk("t5_busy_r1", {31'd0, busy}, 32'd0);
        tick();
        chk("t5_busy_r2", {31'd0, busy}, 32'd1);
        tick();
        chk("t5_cas_r3", {31'd0, cas_pulse}, 32'd1);
        run_to(130);
        chk("t5_done_r130", {31'd0, byte_done}, 32'd1);
        repeat (3) tick();

        // Byte offered while the motor is off.
        motor = 1'b0;
        rel = 0;
        offer(8'h5A);
        chk("t6_ready_r1", {31'd0, bus.in_ready}, 32'd0);
        repeat (4) begin
            tick();
            chk("t6_busy_off", {31'd0, busy}, 32'd0);
        end
        motor = 1'b1;
        tick();
        chk("t6_busy_r6", {31'd0, busy}, 32'd1);
        chk("t6_ready_r6", {31'd0, bus.in_ready}, 32'd1);
        tick();
        chk("t6_cas_r7", {31'd0, cas_pulse}, 32'd1);
        run_to(133);
        chk("t6_busy_r133", {31'd0, busy}, 32'd1);
        tick();
        chk("t6_done_r134", {31'd0, byte_done}, 32'd1);
        repeat (3) tick();

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
